// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back block: default register
// width, register-address width, register count and the queue entry layout.
package regfile_pkg;

    localparam int REG_W  = 16;
    localparam int RADD_W = 3;
    localparam int NREG   = 8;

    // One pending register-file write: destination register and value.
    typedef struct packed {
        logic [RADD_W-1:0] add;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back queue storage: DEPTH entries, up to two pushes and one pop per
// clock. The second push lands in the slot after the first, so the first push
// is the older entry. Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 19
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push0_i,
    input  logic [W-1:0]                 data0_i,
    input  logic                         push1_i,
    input  logic [W-1:0]                 data1_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next pointers and occupancy from this cycle's pushes and pop
    always_comb begin
        wptr_d  = wptr_q + PW'(push0_i) + PW'(push1_i);
        rptr_d  = rptr_q + PW'(pop_i);
        count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
    end

    // Control state: cleared asynchronously so in-flight entries are discarded
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: an entry is only visible while counted
    always_ff @(posedge clk_i) begin
        if (push0_i) mem_q[wptr_q] <= data0_i;
        if (push1_i) mem_q[wptr_q + PW'(1)] <= data1_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter. Accepts results from the ALU and the load
// unit into a shared FIFO (load entry older on a tie) and issues one register
// write per cycle from the head while enabled and not frozen by exec.
// Optional macro WB_SCOREBOARD_EN adds a per-register pending-write mask on
// busy_o; without it busy_o is all zeros and no scoreboard logic exists.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = RADD_W
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        exec_i,
    input  logic                        enable_i,
    input  logic                        alu_valid_i,
    output logic                        alu_ready_o,
    input  logic [ADDR_W-1:0]           alu_add_i,
    input  logic [DATA_W-1:0]           alu_data_i,
    input  logic                        mem_valid_i,
    output logic                        mem_ready_o,
    input  logic [ADDR_W-1:0]           mem_add_i,
    input  logic [DATA_W-1:0]           mem_data_i,
    output logic [ADDR_W-1:0]           wadd_o,
    output logic [DATA_W-1:0]           wdata_o,
    output logic                        wflag_o,
    output logic [2**ADDR_W-1:0]        busy_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int NR = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] add;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [CW-1:0] count;
    entry_t        head;
    entry_t        first;
    entry_t        second;
    logic          mem_acc;
    logic          alu_acc;
    logic          push0;
    logic          push1;
    logic          pop;

    // Admission: readiness looks only at registered occupancy, never at the
    // pop of the same edge; the ALU may take the last slot only when the load
    // unit is not competing for it.
    always_comb begin
        mem_ready_o = (count < CW'(DEPTH));
        alu_ready_o = (count < CW'(DEPTH-1)) ||
                      ((count == CW'(DEPTH-1)) && !mem_valid_i);
        mem_acc     = mem_valid_i && mem_ready_o;
        alu_acc     = alu_valid_i && alu_ready_o;
        push0       = mem_acc || alu_acc;
        push1       = mem_acc && alu_acc;
        first       = mem_acc ? entry_t'{mem_add_i, mem_data_i}
                              : entry_t'{alu_add_i, alu_data_i};
        second      = entry_t'{alu_add_i, alu_data_i};
    end

    // Issue: the head is written whenever something is queued, the file is
    // enabled and not frozen; the write port reads zero while the queue is empty.
    always_comb begin
        wflag_o = (count != '0) && enable_i && !exec_i;
        pop     = wflag_o;
        wadd_o  = (count != '0) ? head.add  : '0;
        wdata_o = (count != '0) ? head.data : '0;
        count_o = count;
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push0_i (push0),
        .data0_i (first),
        .push1_i (push1),
        .data1_i (second),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

`ifdef WB_SCOREBOARD_EN
    logic [CW-1:0] pend_q [NR];
    logic [CW-1:0] pend_d [NR];

    // Pending-write counters: +1 per accepted entry, -1 per issued write
    always_comb begin
        pend_d = pend_q;
        for (int r = 0; r < NR; r++) begin
            if (mem_acc && (mem_add_i == ADDR_W'(r))) pend_d[r] = pend_d[r] + CW'(1);
            if (alu_acc && (alu_add_i == ADDR_W'(r))) pend_d[r] = pend_d[r] + CW'(1);
            if (pop && (head.add == ADDR_W'(r)))      pend_d[r] = pend_d[r] - CW'(1);
        end
    end

    // Counter state, dropped together with the queue on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NR; r++) pend_q[r] <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // A register is busy while at least one queued write targets it
    always_comb begin
        busy_o = '0;
        for (int r = 0; r < NR; r++) busy_o[r] = (pend_q[r] != '0);
    end
`else
    assign busy_o = '0;
`endif

endmodule
